// File: rtl/arb2_pkg.sv
// Shared types and constants for the two-source packet arbiter.
package arb2_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb2_state_t;

   localparam logic SRC0 = 1'b0;
   localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/arb2_mux_dp.sv
// Combinational 2:1 stream datapath: forwards the selected source and steers
// the consumer's ready back to that source only.
module arb2_mux_dp
   import arb2_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              i_en,
   input  logic              i_sel,
   input  logic              i_in0_valid,
   input  logic [DATA_W-1:0] i_in0_data,
   input  logic              i_in0_last,
   input  logic              i_in1_valid,
   input  logic [DATA_W-1:0] i_in1_data,
   input  logic              i_in1_last,
   input  logic              i_out_ready,
   output logic              o_out_valid,
   output logic [DATA_W-1:0] o_out_data,
   output logic              o_out_last,
   output logic              o_in0_ready,
   output logic              o_in1_ready
);

   logic w_valid;
   logic w_last;

   always_comb begin
      w_valid    = (i_sel == SRC1) ? i_in1_valid : i_in0_valid;
      w_last     = (i_sel == SRC1) ? i_in1_last  : i_in0_last;
      o_out_data = (i_sel == SRC1) ? i_in1_data  : i_in0_data;
   end

   // Data is always muxed; only the handshake is qualified by an active grant.
   assign o_out_valid = i_en & w_valid;
   assign o_out_last  = o_out_valid & w_last;
   assign o_in0_ready = i_en & (i_sel == SRC0) & i_out_ready;
   assign o_in1_ready = i_en & (i_sel == SRC1) & i_out_ready;

endmodule

// File: rtl/arb2_mux_ctrl.sv
// Round-robin packet arbiter for two valid/ready sources sharing one output.
// Optional macro ARB2_BURST_LIMIT_EN also releases the grant every MAX_BEATS beats.
module arb2_mux_ctrl
   import arb2_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int MAX_BEATS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in0_valid,
   input  logic [DATA_W-1:0] in0_data,
   input  logic              in0_last,
   output logic              in0_ready,
   input  logic              in1_valid,
   input  logic [DATA_W-1:0] in1_data,
   input  logic              in1_last,
   output logic              in1_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic              sel,
   output logic              busy
);

   localparam int CNT_W = $clog2(MAX_BEATS + 1);

   arb2_state_t      r_state;
   arb2_state_t      w_state_nxt;
   logic             r_sel;
   logic             w_sel_nxt;
   logic             r_prio;
   logic             w_prio_nxt;
   logic [CNT_W-1:0] r_beat_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_beat;
   logic             w_burst_end;
   logic             w_release;

   arb2_mux_dp #(
      .DATA_W (DATA_W)
   ) u_dp (
      .i_en        (busy),
      .i_sel       (r_sel),
      .i_in0_valid (in0_valid),
      .i_in0_data  (in0_data),
      .i_in0_last  (in0_last),
      .i_in1_valid (in1_valid),
      .i_in1_data  (in1_data),
      .i_in1_last  (in1_last),
      .i_out_ready (out_ready),
      .o_out_valid (out_valid),
      .o_out_data  (out_data),
      .o_out_last  (out_last),
      .o_in0_ready (in0_ready),
      .o_in1_ready (in1_ready)
   );

   assign sel  = r_sel;
   assign busy = (r_state == BUSY);

   assign w_beat    = out_valid & out_ready;
   assign w_cnt_inc = (r_beat_cnt == {CNT_W{1'b1}}) ? r_beat_cnt : r_beat_cnt + CNT_W'(1);

`ifdef ARB2_BURST_LIMIT_EN
   assign w_burst_end = (w_cnt_inc == CNT_W'(MAX_BEATS));
`else
   assign w_burst_end = 1'b0;
`endif

   assign w_release = w_beat & (out_last | w_burst_end);

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_prio_nxt  = r_prio;
      w_cnt_nxt   = r_beat_cnt;
      case (r_state)
         IDLE: begin
            if (in0_valid | in1_valid) begin
               w_state_nxt = BUSY;
               w_sel_nxt   = (in0_valid & in1_valid) ? r_prio : (in1_valid ? SRC1 : SRC0);
            end
         end
         BUSY: begin
            if (w_beat) begin
               w_cnt_nxt = w_cnt_inc;
            end
            // Releasing hands the tie-break to the other source for the next IDLE cycle.
            if (w_release) begin
               w_state_nxt = IDLE;
               w_prio_nxt  = ~r_sel;
               w_cnt_nxt   = '0;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_sel      <= SRC0;
         r_prio     <= SRC0;
         r_beat_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_sel      <= w_sel_nxt;
         r_prio     <= w_prio_nxt;
         r_beat_cnt <= w_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_arb2_mux_ctrl.sv
// Scoreboard bench for arb2_mux_ctrl: packet-level reference arbiter plus directed ordering checks.
module tb_arb2_mux_ctrl;

   localparam int DATA_W    = 8;
   localparam int MAX_BEATS = 4;
`ifdef ARB2_BURST_LIMIT_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in0_valid = 1'b0, in1_valid = 1'b0;
   logic [DATA_W-1:0] in0_data = '0, in1_data = '0;
   logic              in0_last = 1'b0, in1_last = 1'b0;
   logic              in0_ready, in1_ready;
   logic              out_valid, out_last, sel, busy;
   logic [DATA_W-1:0] out_data;
   logic              out_ready = 1'b1;

   always #5 clk = ~clk;

   arb2_mux_ctrl #(.DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS)) dut (
      .clk(clk), .rst_n(rst_n),
      .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
      .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
      .sel(sel), .busy(busy)
   );

   typedef struct packed {
      logic [DATA_W-1:0] d;
      logic              l;
   } beat_t;

   beat_t             q0[$], q1[$], exp_q[$];
   logic [DATA_W-1:0] obs[$], seq[$];
   int   errors = 0, checks = 0;
   int   gap0 = 0, gap1 = 0, rdy_pct = 100;
   bit   rdy_rand = 1'b0, chk_en = 1'b0;
   logic f_ready = 1'b1;
   logic acc0 = 1'b0, acc1 = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference arbiter: which source owns the output (-1 = nobody), who wins ties, beats so far.
   int   m_own = -1, m_sel = 0, m_fav = 0, m_cnt = 0;
   logic m_v, m_l;
   logic [DATA_W-1:0] m_d;

   always @(negedge clk) begin
      if (chk_en) begin
         m_d = (m_sel == 1) ? in1_data  : in0_data;
         m_v = (m_sel == 1) ? in1_valid : in0_valid;
         m_l = (m_sel == 1) ? in1_last  : in0_last;
         check("busy", busy, m_own >= 0);
         check("sel", sel, m_sel);
         check("out_valid", out_valid, (m_own >= 0) && m_v);
         check("out_data", out_data, m_d);
         check("out_last", out_last, (m_own >= 0) && m_v && m_l);
         check("in0_ready", in0_ready, (m_own == 0) && out_ready);
         check("in1_ready", in1_ready, (m_own == 1) && out_ready);
         if (!rst_n) begin
            m_own = -1; m_sel = 0; m_fav = 0; m_cnt = 0;
         end else if (m_own < 0) begin
            if (in0_valid || in1_valid) begin
               m_own = (in0_valid && in1_valid) ? m_fav : (in1_valid ? 1 : 0);
               m_sel = m_own;
            end
         end else if (m_v && out_ready) begin
            exp_q.push_back({m_d, m_l});
            m_cnt++;
            if (m_l || (BURST && m_cnt == MAX_BEATS)) begin
               m_fav = 1 - m_own;
               m_own = -1;
               m_cnt = 0;
            end
         end
      end
   end

   // Monitor: every transfer the DUT presents is popped against the scoreboard.
   beat_t e;
   always @(negedge clk) begin
      #1;
      acc0 = rst_n & in0_valid & in0_ready;
      acc1 = rst_n & in1_valid & in1_ready;
      if (chk_en && rst_n && out_valid && out_ready) begin
         obs.push_back(out_data);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h expected none at %0t", out_data, $time);
         end else begin
            e = exp_q.pop_front();
            check("beat_data", out_data, e.d);
            check("beat_last", out_last, e.l);
         end
      end
   end

   initial forever begin
      @(posedge clk); #1;
      out_ready = rdy_rand ? ($urandom_range(99) < rdy_pct) : f_ready;
   end

   initial forever begin
      @(posedge clk); #1;
      if (acc0 && q0.size() > 0) q0.delete(0);
      if (acc0 || !in0_valid) begin
         if (q0.size() > 0 && $urandom_range(99) >= gap0) begin
            in0_valid = 1'b1;
            {in0_data, in0_last} = q0[0];
         end else in0_valid = 1'b0;
      end
   end

   initial forever begin
      @(posedge clk); #1;
      if (acc1 && q1.size() > 0) q1.delete(0);
      if (acc1 || !in1_valid) begin
         if (q1.size() > 0 && $urandom_range(99) >= gap1) begin
            in1_valid = 1'b1;
            {in1_data, in1_last} = q1[0];
         end else in1_valid = 1'b0;
      end
   end

   task automatic drain(input int budget);
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || in0_valid || in1_valid || busy) && n < budget) begin
         @(negedge clk); #2;
         n++;
      end
      repeat (3) @(negedge clk);
      #2;
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL drain_timeout: got %0d cycles required under %0d", n, budget);
      end
   endtask

   task automatic wait_obs(input int target);
      int n = 0;
      while (obs.size() < target && n < 200) begin
         @(negedge clk); #2;
         n++;
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL wait_beats: got %0d beats required %0d", obs.size(), target);
      end
   endtask

   task automatic check_seq(input string nm, input int base);
      for (int i = 0; i < seq.size(); i++) begin
         if (base + i < obs.size()) check(nm, obs[base+i], seq[i]);
         else check(nm, 32'hFFFF_FFFF, seq[i]);
      end
      check({nm, "_count"}, obs.size() - base, seq.size());
   endtask

   int base;

   initial begin
      // Reset held for two edges while in0 already offers a packet
      q0.push_back({8'h01, 1'b1});
      @(posedge clk); #1 chk_en = 1'b1;
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk); #2;
      check("t1_busy", busy, 1);
      check("t1_sel", sel, 0);
      drain(100);

      // Single source on in1
      base = obs.size();
      q1.push_back({8'hA1, 1'b0}); q1.push_back({8'hA2, 1'b0}); q1.push_back({8'hA3, 1'b1});
      drain(100);
      seq = '{8'hA1, 8'hA2, 8'hA3};
      check_seq("t2_order", base);

      // Round robin with both sources always offering one-beat packets
      base = obs.size();
      for (int i = 0; i < 3; i++) begin
         q0.push_back({8'h10 + 8'(i), 1'b1});
         q1.push_back({8'h20 + 8'(i), 1'b1});
      end
      drain(100);
      seq = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
      check_seq("t3_order", base);

      // Backpressure for four cycles after the second beat
      base = obs.size();
      for (int i = 0; i < 4; i++) q0.push_back({8'h30 + 8'(i), i == 3});
      q1.push_back({8'h40, 1'b1});
      wait_obs(base + 2);
      f_ready = 1'b0;
      repeat (4) begin
         @(negedge clk); #2;
         check("t4_in0_ready", in0_ready, 0);
         check("t4_data_hold", out_data, 8'h32);
         check("t4_sel", sel, 0);
      end
      f_ready = 1'b1;
      drain(100);
      seq = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h40};
      check_seq("t4_order", base);

      // Six-beat packet against a waiting one-beat packet
      base = obs.size();
      for (int i = 0; i < 6; i++) q0.push_back({8'h50 + 8'(i), i == 5});
      q1.push_back({8'h60, 1'b1});
      drain(100);
      if (BURST) seq = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h54, 8'h55};
      else       seq = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h60};
      check_seq("t5_order", base);

      // Reset after two of five in1 beats, then both sources contend
      base = obs.size();
      for (int i = 0; i < 5; i++) q1.push_back({8'h70 + 8'(i), i == 4});
      wait_obs(base + 2);
      f_ready = 1'b0;
      q0.push_back({8'h80, 1'b1});
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      #1 f_ready = 1'b1;
      @(negedge clk); #2;
      check("t6_busy", busy, 0);
      check("t6_sel", sel, 0);
      base = obs.size();
      drain(100);
      seq = '{8'h80, 8'h72, 8'h73, 8'h74};
      check_seq("t6_order", base);

      // Randomized traffic, gaps and backpressure
      gap0 = 30; gap1 = 30; rdy_pct = 70; rdy_rand = 1'b1;
      for (int p = 0; p < 30; p++) begin
         int len0, len1;
         len0 = $urandom_range(6, 1);
         len1 = $urandom_range(6, 1);
         for (int b = 0; b < len0; b++) q0.push_back({8'($urandom), b == len0 - 1});
         for (int b = 0; b < len1; b++) q1.push_back({8'($urandom), b == len1 - 1});
      end
      drain(6000);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got time %0t required completion", $time);
      $fatal(1);
   end

endmodule
